instruction_fetch_unit: RTL and testbench

- Fetch stage of the RV64 datapath. Holds the program counter and issues one word-aligned request at a time to instruction memory.
- Presents the returned 32-bit instruction, with its PC, to decode over a valid/ready handshake.
- Its if_instr output feeds the immediate generator and the decoder directly.
- Accepts branch/jump redirects from execute and squashes any stale in-flight fetch.

---
 rtl/rv_fetch_pkg.sv | 14 +
 rtl/pc_register.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the RV64 fetch stage
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          PC_INC           = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - fetch program counter with redirect load and sequential increment
module pc_register
    import rv_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en_i,
    input  logic [PC_WIDTH-1:0] load_val_i,
    input  logic                inc_en_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // A redirect always wins over the sequential step; the add wraps silently.
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_val_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + PC_WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with redirect squash
module instruction_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc
);

    fetch_state_e           state_q;
    logic                   drop_q;
    logic                   req_valid_q;
    logic                   if_valid_q;
    logic [INSTR_WIDTH-1:0] if_instr_q;
    logic [PC_WIDTH-1:0]    if_pc_q;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    redirect_aligned;
    logic                   pc_inc_en;

    assign redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign pc_inc_en        = (state_q == ST_OUT) && if_ready;

    pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (redirect_valid),
        .load_val_i (redirect_aligned),
        .inc_en_i   (pc_inc_en),
        .pc_o       (fetch_pc)
    );

    // req_valid_q is asserted for the cycle after entering REQ, so a reset
    // release never issues a request combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= INSTR_WIDTH'(NOP_INSTR);
            if_pc_q     <= RESET_PC;
        end else begin
            req_valid_q <= 1'b0;
            case (state_q)
                ST_REQ: begin
                    if (req_valid_q && imem_req_ready) begin
                        state_q <= ST_WAIT;
                        drop_q  <= redirect_valid;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q || redirect_valid) begin
                            drop_q      <= 1'b0;
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            if_instr_q <= imem_rsp_data;
                            if_pc_q    <= fetch_pc;
                            if_valid_q <= 1'b1;
                            state_q    <= ST_OUT;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (redirect_valid || if_ready) begin
                        if_valid_q  <= 1'b0;
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_REQ;
                    drop_q     <= 1'b0;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - cycle-table bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        rd;
        logic [63:0] rpc;
        logic        ifr;
        logic        e_qv;
        logic [63:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    task automatic v(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic rd, input logic [63:0] rpc, input logic ifr,
                     input logic e_qv, input logic [63:0] e_addr, input logic e_ifv,
                     input logic [31:0] e_instr, input logic [63:0] e_pc);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rv = rv; t.rdata = rdata; t.rd = rd; t.rpc = rpc; t.ifr = ifr;
        t.e_qv = e_qv; t.e_addr = e_addr; t.e_ifv = e_ifv; t.e_instr = e_instr; t.e_pc = e_pc;
        vq.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: vector table did not complete");
        $finish;
    end

    initial begin
        v(0, 0, 0, 32'h0,        0, 64'h0,   0,   0, 64'h0,    0, NOP,          64'h0);
        v(0, 0, 0, 32'h0,        0, 64'h0,   0,   0, 64'h0,    0, NOP,          64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h0,    0, NOP,          64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h0,    0, NOP,          64'h0);
        v(1, 1, 1, 32'h00500093, 0, 64'h0,   1,   0, 64'h0,    0, NOP,          64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h0,    1, 32'h00500093, 64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h4,    0, 32'h00500093, 64'h0);
        v(1, 1, 1, 32'h00A00113, 0, 64'h0,   1,   0, 64'h4,    0, 32'h00500093, 64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h4,    1, 32'h00A00113, 64'h4);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   1, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   1, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   1, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   1, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 1, 1, 32'h00300193, 0, 64'h0,   1,   0, 64'h8,    0, 32'h00A00113, 64'h4);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h8,    1, 32'h00300193, 64'h8);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'hC,    0, 32'h00300193, 64'h8);
        v(1, 1, 1, 32'h00400213, 0, 64'h0,   1,   0, 64'hC,    0, 32'h00300193, 64'h8);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'hC,    1, 32'h00400213, 64'hC);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h10,   0, 32'h00400213, 64'hC);
        v(1, 1, 0, 32'h0,        1, 64'h103, 1,   0, 64'h10,   0, 32'h00400213, 64'hC);
        v(1, 1, 1, 32'hDEADBEEF, 0, 64'h0,   1,   0, 64'h100,  0, 32'h00400213, 64'hC);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h100,  0, 32'h00400213, 64'hC);
        v(1, 1, 1, 32'h00500293, 0, 64'h0,   0,   0, 64'h100,  0, 32'h00400213, 64'hC);
        v(1, 1, 0, 32'h0,        0, 64'h0,   0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        0, 64'h0,   0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        0, 64'h0,   0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        0, 64'h0,   0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        0, 64'h0,   0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        1, 64'h40,  0,   0, 64'h100,  1, 32'h00500293, 64'h100);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h40,   0, 32'h00500293, 64'h100);
        v(1, 1, 1, 32'h00600313, 0, 64'h0,   1,   0, 64'h40,   0, 32'h00500293, 64'h100);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   0, 64'h40,   1, 32'h00600313, 64'h40);
        v(1, 0, 0, 32'h0,        1, 64'h20,  1,   1, 64'h44,   0, 32'h00600313, 64'h40);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h20,   0, 32'h00600313, 64'h40);
        v(1, 1, 1, 32'h00700393, 0, 64'h0,   1,   0, 64'h20,   0, 32'h00600313, 64'h40);
        v(1, 1, 0, 32'h0,        1, 64'h200, 1,   0, 64'h20,   1, 32'h00700393, 64'h20);
        v(1, 1, 0, 32'h0,        1, 64'h300, 1,   1, 64'h200,  0, 32'h00700393, 64'h20);
        v(1, 1, 1, 32'h00000BAD, 0, 64'h0,   1,   0, 64'h300,  0, 32'h00700393, 64'h20);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h300,  0, 32'h00700393, 64'h20);
        v(1, 1, 1, 32'h00800413, 1, 64'h306, 1,   0, 64'h300,  0, 32'h00700393, 64'h20);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h304,  0, 32'h00700393, 64'h20);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h304,  0, 32'h00700393, 64'h20);
        v(1, 1, 1, 32'h00900493, 0, 64'h0,   1,   0, 64'h304,  0, 32'h00700393, 64'h20);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   0, 64'h304,  1, 32'h00900493, 64'h304);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, 64'h308,  0, 32'h00900493, 64'h304);
        v(0, 0, 0, 32'h0,        0, 64'h0,   0,   0, 64'h0,    0, NOP,          64'h0);
        v(1, 0, 1, 32'h0BADBAD0, 0, 64'h0,   1,   0, 64'h0,    0, NOP,          64'h0);
        v(1, 0, 1, 32'h0BADBAD0, 0, 64'h0,   1,   1, 64'h0,    0, NOP,          64'h0);
        v(1, 0, 0, 32'h0,        1, ONES,    1,   1, 64'h0,    0, NOP,          64'h0);
        v(1, 1, 0, 32'h0,        0, 64'h0,   1,   1, ONES - 64'h3, 0, NOP,      64'h0);
        v(1, 1, 1, 32'h0000006F, 0, 64'h0,   1,   0, ONES - 64'h3, 0, NOP,      64'h0);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   0, ONES - 64'h3, 1, 32'h0000006F, ONES - 64'h3);
        v(1, 0, 0, 32'h0,        0, 64'h0,   1,   1, 64'h0,    0, 32'h0000006F, ONES - 64'h3);

        @(posedge clk);
        #1;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h0 || if_valid !== 1'b0 ||
            if_instr !== NOP || if_pc !== 64'h0) begin
            n_miscompares++;
            $display("FAIL reset state: qv=%0b addr=%h ifv=%0b instr=%h pc=%h",
                     imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc);
        end

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n          = vq[i].rst;
            imem_req_ready = vq[i].rdy;
            imem_rsp_valid = vq[i].rv;
            imem_rsp_data  = vq[i].rdata;
            redirect_valid = vq[i].rd;
            redirect_pc    = vq[i].rpc;
            if_ready       = vq[i].ifr;
            #1;
            n_applied++;
            if (imem_req_valid !== vq[i].e_qv || imem_req_addr !== vq[i].e_addr ||
                if_valid !== vq[i].e_ifv || if_instr !== vq[i].e_instr || if_pc !== vq[i].e_pc) begin
                n_miscompares++;
                $display("FAIL vec%0d: got qv=%0b addr=%h ifv=%0b instr=%h pc=%h, exp qv=%0b addr=%h ifv=%0b instr=%h pc=%h",
                         i, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
                         vq[i].e_qv, vq[i].e_addr, vq[i].e_ifv, vq[i].e_instr, vq[i].e_pc);
            end
        end

        if (n_applied != vq.size()) begin
            n_miscompares++;
            $display("FAIL vector count: applied %0d of %0d", n_applied, vq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        if (n_miscompares == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
